// File: rtl/vdcm_ecg_pkg.sv
// rtl/vdcm_ecg_pkg.sv - shared types and codeword helpers for the ECG parser
package vdcm_ecg_pkg;

  typedef enum logic {EC_XFM = 1'b0, EC_BP = 1'b1} ec_mode_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} parse_state_e;

  localparam int MAX_PREFIX   = 8;
  localparam int MAX_BITS_REQ = MAX_PREFIX + 1;

  // k is the substream-selected XFM table (SSM_IDX-1); BP ignores it.
  function automatic logic [3:0] bits_req_from_cw(input logic [3:0] cw, input ec_mode_e mode,
                                                  input int k);
    logic [3:0] br;
    br = cw + 4'd1;
    if (mode == EC_XFM) begin
      if (k == 0) begin
        if (cw <= 4'd3)      br = cw + 4'd2;
        else if (cw == 4'd4) br = 4'd1;
      end else begin
        if (cw == 4'd0)      br = 4'd2;
        else if (cw == 4'd1) br = 4'd1;
      end
    end
    return br;
  endfunction

  // Result is a 16-bit two's complement value; callers keep the low COEFF_W bits.
  function automatic logic [15:0] to_twos_comp(input logic [MAX_BITS_REQ-1:0] field,
                                               input logic [3:0] br);
    logic [15:0] f;
    f = 16'(field);
    if (f >= (16'd1 << (br - 4'd1))) f = f - (16'd1 << br);
    return f;
  endfunction

endpackage

// File: rtl/ecg_decode_comb.sv
// rtl/ecg_decode_comb.sv - combinational decode of one ECG from a bit-aligned window
module ecg_decode_comb
  import vdcm_ecg_pkg::*;
#(
  parameter int MAX_SAMPLES = 7,
  parameter int COEFF_W     = 9,
  parameter int WIN_W       = 128,
  parameter int SSM_IDX     = 1,
  localparam int NS_W       = $clog2(MAX_SAMPLES + 1)
) (
  input  logic [WIN_W-1:0]               win,
  input  ec_mode_e                       mode,
  input  logic                           ecg_sm,
  input  logic [NS_W-1:0]                num_sample,
  output logic [MAX_SAMPLES*COEFF_W-1:0] coeff,
  output logic [MAX_SAMPLES-1:0]         sign_vld,
  output logic [7:0]                     bits_used
);

  logic [3:0]              prefix;
  logic [3:0]              prefix_bits;
  logic [3:0]              br;
  logic                    stop;
  logic [7:0]              pos;
  logic [WIN_W-1:0]        shifted;
  logic [MAX_BITS_REQ-1:0] field;
  logic [15:0]             lane;

  always_comb begin
    prefix = '0;
    stop   = 1'b0;
    for (int j = 0; j < MAX_PREFIX; j++) begin
      if (!stop && win[WIN_W-2-j]) prefix = prefix + 4'd1;
      else                         stop   = 1'b1;
    end
    // a saturated prefix carries no terminating zero
    prefix_bits = (prefix == 4'(MAX_PREFIX)) ? prefix : prefix + 4'd1;
    br          = bits_req_from_cw(prefix, mode, SSM_IDX - 1);
  end

  always_comb begin
    coeff     = '0;
    sign_vld  = '0;
    bits_used = 8'd1;
    pos       = '0;
    shifted   = '0;
    field     = '0;
    lane      = '0;
    if (!win[WIN_W-1]) begin
      for (int i = 0; i < MAX_SAMPLES; i++) begin
        if (i < int'(num_sample)) begin
          pos     = 8'd1 + 8'(prefix_bits) + 8'(i) * 8'(br);
          shifted = win << pos;
          field   = shifted[WIN_W-1 -: MAX_BITS_REQ] >> (4'(MAX_BITS_REQ) - br);
          if (ecg_sm) begin
            lane        = 16'(field);
            sign_vld[i] = |field;
          end else begin
            lane = to_twos_comp(field, br);
          end
          coeff[i*COEFF_W +: COEFF_W] = lane[COEFF_W-1:0];
        end
      end
      bits_used = 8'd1 + 8'(prefix_bits) + 8'(num_sample) * 8'(br);
    end
  end

endmodule

// File: rtl/ecg_parse_seq.sv
// rtl/ecg_parse_seq.sv - sequential ECG parser: block FSM, handshakes, output register
// ECG_PARSE_STATS_EN adds saturating stat_skip_cnt / stat_bits_cnt ports.
module ecg_parse_seq
  import vdcm_ecg_pkg::*;
#(
  parameter int NUM_ECG     = 4,
  parameter int MAX_SAMPLES = 7,
  parameter int COEFF_W     = 9,
  parameter int WIN_W       = 128,
  parameter int SM_ECG_CNT  = 3,
  parameter int SSM_IDX     = 1,
  localparam int IDX_W      = $clog2(NUM_ECG),
  localparam int NS_W       = $clog2(MAX_SAMPLES + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           blk_start,
  input  logic                           cfg_mode_xfm,
  input  logic [NS_W-1:0]                cfg_num_sample,
  input  logic                           win_valid,
  output logic                           win_ready,
  input  logic [WIN_W-1:0]               win_data,
  output logic [7:0]                     bits_used,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               out_ecg_idx,
  output logic [MAX_SAMPLES*COEFF_W-1:0] out_coeff,
  output logic [MAX_SAMPLES-1:0]         out_sign_vld,
  output logic                           blk_done
`ifdef ECG_PARSE_STATS_EN
  ,
  output logic [15:0]                    stat_skip_cnt,
  output logic [23:0]                    stat_bits_cnt
`endif
);

  localparam int CNT_W = $clog2(NUM_ECG + 1);

  parse_state_e                   state, state_nxt;
  logic [CNT_W-1:0]               cnt_in;
  ec_mode_e                       cfg_mode;
  logic [NS_W-1:0]                cfg_n;
  logic                           accept;
  logic                           start;
  logic                           ecg_sm;
  logic [MAX_SAMPLES*COEFF_W-1:0] dec_coeff;
  logic [MAX_SAMPLES-1:0]         dec_sign;
  logic [7:0]                     dec_bits;

  assign accept    = win_valid && win_ready;
  assign start     = (state == ST_IDLE) && blk_start;
  assign ecg_sm    = int'(cnt_in) < SM_ECG_CNT;
  assign bits_used = win_ready ? dec_bits : 8'd0;

  ecg_decode_comb #(
    .MAX_SAMPLES (MAX_SAMPLES),
    .COEFF_W     (COEFF_W),
    .WIN_W       (WIN_W),
    .SSM_IDX     (SSM_IDX)
  ) u_decode (
    .win        (win_data),
    .mode       (cfg_mode),
    .ecg_sm     (ecg_sm),
    .num_sample (cfg_n),
    .coeff      (dec_coeff),
    .sign_vld   (dec_sign),
    .bits_used  (dec_bits)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    win_ready = 1'b0;
    blk_done  = 1'b0;
    case (state)
      ST_IDLE: if (blk_start) state_nxt = ST_RUN;
      ST_RUN: begin
        win_ready = (cnt_in < CNT_W'(NUM_ECG)) && (!out_valid || out_ready);
        if (out_valid && out_ready && out_ecg_idx == IDX_W'(NUM_ECG - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        blk_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_in       <= '0;
      cfg_mode     <= EC_XFM;
      cfg_n        <= '0;
      out_valid    <= 1'b0;
      out_ecg_idx  <= '0;
      out_coeff    <= '0;
      out_sign_vld <= '0;
    end else begin
      if (start) begin
        cnt_in   <= '0;
        cfg_mode <= cfg_mode_xfm ? EC_XFM : EC_BP;
        cfg_n    <= (cfg_num_sample == '0 || int'(cfg_num_sample) > MAX_SAMPLES)
                    ? NS_W'(MAX_SAMPLES) : cfg_num_sample;
      end
      // one-entry register: a new result may replace the one leaving this cycle
      if (accept) begin
        cnt_in       <= cnt_in + 1'b1;
        out_valid    <= 1'b1;
        out_ecg_idx  <= cnt_in[IDX_W-1:0];
        out_coeff    <= dec_coeff;
        out_sign_vld <= dec_sign;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ECG_PARSE_STATS_EN
  logic [24:0] bits_sum;
  assign bits_sum = {1'b0, stat_bits_cnt} + 25'(dec_bits);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      stat_skip_cnt <= '0;
      stat_bits_cnt <= '0;
    end else if (accept) begin
      if (win_data[WIN_W-1] && stat_skip_cnt != 16'hFFFF) stat_skip_cnt <= stat_skip_cnt + 16'd1;
      stat_bits_cnt <= bits_sum[24] ? 24'hFF_FFFF : bits_sum[23:0];
    end
  end
`endif

endmodule
